// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/RAM.
// The sequencer is the master; the datapath side is the slave.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zFlag;
  logic       moc;

  logic       pcLoad;
  logic       npcLoad;
  logic       irLoad;
  logic       marLoad;
  logic       mdrLoad;
  logic       marSource;
  logic       mdrSource;
  logic       memEnable;
  logic       rw;
  logic       regWrite;
  logic       regDst;
  logic       rfSource;
  logic       aluSource;
  logic [5:0] aluCode;
  logic [1:0] pcSelect;
  logic       illegal;
  logic       error;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zFlag, moc,
    output pcLoad, npcLoad, irLoad, marLoad, mdrLoad, marSource, mdrSource,
           memEnable, rw, regWrite, regDst, rfSource, aluSource, aluCode,
           pcSelect, illegal, error, state
  );

  modport slave (
    output opcode, funct, zFlag, moc,
    input  pcLoad, npcLoad, irLoad, marLoad, mdrLoad, marSource, mdrSource,
           memEnable, rw, regWrite, regDst, rfSource, aluSource, aluCode,
           pcSelect, illegal, error, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore multi-cycle sequencer for the MIPS datapath (R-type, addi, lw, sw, beq, j)
// with a moc watchdog that traps hung memory accesses into a sticky ERROR state.
module multicycle_control #(
  parameter int MOC_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH0 = 4'd1,
    S_FETCH1 = 4'd2,
    S_FETCH2 = 4'd3,
    S_DECODE = 4'd4,
    S_R_EXEC = 4'd5,
    S_I_EXEC = 4'd6,
    S_ADDR   = 4'd7,
    S_LW_MEM = 4'd8,
    S_LW_WB  = 4'd9,
    S_SW_MDR = 4'd10,
    S_SW_MEM = 4'd11,
    S_BEQ    = 4'd12,
    S_JUMP   = 4'd13,
    S_ERROR  = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_load;
    logic       npc_load;
    logic       ir_load;
    logic       mar_load;
    logic       mdr_load;
    logic       mar_src;
    logic       mdr_src;
    logic       mem_en;
    logic       rw;
    logic       reg_write;
    logic       reg_dst;
    logic       rf_src;
    logic       alu_src;
    logic [5:0] alu_code;
    logic [1:0] pc_sel;
    logic       err;
  } ctrl_t;

  localparam int CW = (MOC_TIMEOUT < 1) ? 1 : $clog2(MOC_TIMEOUT + 1);
  // Trap on the MOC_TIMEOUT-th consecutive wait cycle without moc.
  localparam logic [CW-1:0] WD_LAST = CW'(MOC_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  state_t        state_q, state_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  ctrl_t         ctrl_q, ctrl_d;

  function automatic logic is_wait(input state_t s);
    return (s == S_FETCH1) || (s == S_LW_MEM) || (s == S_SW_MEM);
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c    = '0;
    c.rw = 1'b1;
    case (s)
      S_FETCH0: begin c.mar_load = 1'b1; c.npc_load = 1'b1; end
      S_FETCH1: c.mem_en = 1'b1;
      S_FETCH2: begin c.mem_en = 1'b1; c.ir_load = 1'b1; c.pc_load = 1'b1; end
      S_R_EXEC: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_I_EXEC: begin c.alu_src = 1'b1; c.alu_code = 6'h20; c.reg_write = 1'b1; end
      S_ADDR: begin
        c.alu_src  = 1'b1;
        c.alu_code = 6'h20;
        c.mar_src  = 1'b1;
        c.mar_load = 1'b1;
      end
      S_LW_MEM: begin c.mem_en = 1'b1; c.mdr_src = 1'b1; c.mdr_load = 1'b1; end
      S_LW_WB:  begin c.reg_write = 1'b1; c.rf_src = 1'b1; end
      S_SW_MDR: c.mdr_load = 1'b1;
      S_SW_MEM: begin c.mem_en = 1'b1; c.rw = 1'b0; end
      S_BEQ:    begin c.alu_code = 6'h22; c.pc_sel = 2'd1; end
      S_JUMP:   begin c.pc_load = 1'b1; c.pc_sel = 2'd2; end
      S_ERROR:  c.err = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  logic op_legal;
  assign op_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_ADDI) ||
                    (bus.opcode == OP_LW)    || (bus.opcode == OP_SW)   ||
                    (bus.opcode == OP_BEQ)   || (bus.opcode == OP_J);

  always_comb begin
    state_d  = state_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: begin
        if (bus.moc)                  state_d = S_FETCH2;
        else if (wd_cnt_q == WD_LAST) state_d = S_ERROR;
      end
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH0;
        endcase
      end
      S_R_EXEC, S_I_EXEC, S_LW_WB, S_BEQ, S_JUMP: state_d = S_FETCH0;
      S_ADDR:   state_d = (bus.opcode == OP_SW) ? S_SW_MDR : S_LW_MEM;
      S_LW_MEM: begin
        if (bus.moc)                  state_d = S_LW_WB;
        else if (wd_cnt_q == WD_LAST) state_d = S_ERROR;
      end
      S_SW_MDR: state_d = S_SW_MEM;
      S_SW_MEM: begin
        if (bus.moc)                  state_d = S_FETCH0;
        else if (wd_cnt_q == WD_LAST) state_d = S_ERROR;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    if (is_wait(state_d) && (state_d != state_q)) begin
      wd_cnt_d = '0;
    end else if (is_wait(state_q) && !bus.moc) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end

    ctrl_d = ctrl_of(state_d);
  end

  // Control word is registered from the next state, so it always matches state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wd_cnt_q <= '0;
      ctrl_q   <= ctrl_of(S_IDLE);
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Only beq's pcLoad, R-type's ALU function and the illegal flag follow live inputs.
  assign bus.pcLoad    = (state_q == S_BEQ) ? bus.zFlag : ctrl_q.pc_load;
  assign bus.aluCode   = (state_q == S_R_EXEC) ? bus.funct : ctrl_q.alu_code;
  assign bus.illegal   = (state_q == S_DECODE) && !op_legal;
  assign bus.npcLoad   = ctrl_q.npc_load;
  assign bus.irLoad    = ctrl_q.ir_load;
  assign bus.marLoad   = ctrl_q.mar_load;
  assign bus.mdrLoad   = ctrl_q.mdr_load;
  assign bus.marSource = ctrl_q.mar_src;
  assign bus.mdrSource = ctrl_q.mdr_src;
  assign bus.memEnable = ctrl_q.mem_en;
  assign bus.rw        = ctrl_q.rw;
  assign bus.regWrite  = ctrl_q.reg_write;
  assign bus.regDst    = ctrl_q.reg_dst;
  assign bus.rfSource  = ctrl_q.rf_src;
  assign bus.aluSource = ctrl_q.alu_src;
  assign bus.pcSelect  = ctrl_q.pc_sel;
  assign bus.error     = ctrl_q.err;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected state/control words are queued
// as stimulus is driven and popped against the DUT on the falling edge.
module tb_multicycle_control;

  localparam int SKIP = -1;
  localparam int S_IDLE = 0, S_F0 = 1, S_F1 = 2, S_F2 = 3, S_DEC = 4, S_REX = 5,
                 S_IEX = 6, S_ADDR = 7, S_LWM = 8, S_LWB = 9, S_SWMDR = 10,
                 S_SWM = 11, S_BEQ = 12, S_JMP = 13, S_ERR = 15;

  typedef struct packed {
    logic [3:0]  st;
    logic [22:0] ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] nxt_op = 6'h00;
  logic [5:0] nxt_fn = 6'h20;
  logic       nxt_z  = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  multicycle_control_if bus ();

  multicycle_control #(.MOC_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected control word straight from the per-state output table.
  function automatic logic [22:0] spec_out(input logic [3:0] s, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z);
    logic pcl, npcl, irl, marl, mdrl, mars, mdrs, me, rwv, rgw, rgd, rfs, alus, ill, err;
    logic [5:0] ac;
    logic [1:0] ps;
    {pcl, npcl, irl, marl, mdrl, mars, mdrs, me, rgw, rgd, rfs, alus, ill, err} = '0;
    rwv = 1'b1;
    ac  = 6'h00;
    ps  = 2'd0;
    case (s)
      4'd1:  begin marl = 1; npcl = 1; end
      4'd2:  me = 1;
      4'd3:  begin me = 1; irl = 1; pcl = 1; end
      4'd4:  ill = !(op == 6'h00 || op == 6'h08 || op == 6'h23 ||
                     op == 6'h2B || op == 6'h04 || op == 6'h02);
      4'd5:  begin ac = fn; rgd = 1; rgw = 1; end
      4'd6:  begin alus = 1; ac = 6'h20; rgw = 1; end
      4'd7:  begin alus = 1; ac = 6'h20; mars = 1; marl = 1; end
      4'd8:  begin me = 1; mdrs = 1; mdrl = 1; end
      4'd9:  begin rgw = 1; rfs = 1; end
      4'd10: mdrl = 1;
      4'd11: begin me = 1; rwv = 0; end
      4'd12: begin ac = 6'h22; ps = 2'd1; pcl = z; end
      4'd13: begin pcl = 1; ps = 2'd2; end
      4'd15: err = 1;
      default: ;
    endcase
    return {pcl, npcl, irl, marl, mdrl, mars, mdrs, me, rwv, rgw, rgd, rfs, alus,
            ac, ps, ill, err};
  endfunction

  task automatic step(input int exp_st, input logic moc_v, input logic rst_v);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst_v;
    bus.moc    = moc_v;
    bus.opcode = nxt_op;
    bus.funct  = nxt_fn;
    bus.zFlag  = nxt_z;
    if (exp_st != SKIP) begin
      e.st   = exp_st[3:0];
      e.ctrl = spec_out(exp_st[3:0], nxt_op, nxt_fn, nxt_z);
      sb_q.push_back(e);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int f1_waits, input int mem_waits);
    nxt_op = op;
    nxt_fn = fn;
    nxt_z  = z;
    step(S_F0, (f1_waits == 0), 1'b0);
    for (int i = 0; i < f1_waits; i++) step(S_F1, 1'b0, 1'b0);
    step(S_F1, 1'b1, 1'b0);
    step(S_F2, 1'b1, 1'b0);
    step(S_DEC, 1'b1, 1'b0);
    case (op)
      6'h00: step(S_REX, 1'b1, 1'b0);
      6'h08: step(S_IEX, 1'b1, 1'b0);
      6'h23: begin
        step(S_ADDR, 1'b0, 1'b0);
        for (int i = 0; i < mem_waits; i++) step(S_LWM, 1'b0, 1'b0);
        step(S_LWM, 1'b1, 1'b0);
        step(S_LWB, 1'b1, 1'b0);
      end
      6'h2B: begin
        step(S_ADDR, 1'b0, 1'b0);
        step(S_SWMDR, 1'b1, 1'b0);
        for (int i = 0; i < mem_waits; i++) step(S_SWM, 1'b0, 1'b0);
        step(S_SWM, 1'b1, 1'b0);
      end
      6'h04: step(S_BEQ, 1'b1, 1'b0);
      6'h02: step(S_JMP, 1'b1, 1'b0);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [22:0] obs;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      obs = {bus.pcLoad, bus.npcLoad, bus.irLoad, bus.marLoad, bus.mdrLoad,
             bus.marSource, bus.mdrSource, bus.memEnable, bus.rw, bus.regWrite,
             bus.regDst, bus.rfSource, bus.aluSource, bus.aluCode, bus.pcSelect,
             bus.illegal, bus.error};
      check_eq($sformatf("state(exp %0d)", e.st), {28'd0, bus.state}, {28'd0, e.st});
      check_eq($sformatf("ctrl@state%0d", e.st), {9'd0, obs}, {9'd0, e.ctrl});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    bus.moc    = 1'b0;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zFlag  = 1'b0;

    step(SKIP, 1'b0, 1'b1);
    step(S_IDLE, 1'b0, 1'b0);

    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h08, 6'h00, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 2);
    run_instr(6'h2B, 6'h00, 1'b0, 3, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 1, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);

    // Hung fetch: trap on the 4th wait cycle, stay trapped until reset.
    nxt_op = 6'h00;
    step(S_F0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(S_F1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(S_ERR, (i % 2 == 1), 1'b0);
    step(S_ERR, 1'b0, 1'b1);
    step(S_IDLE, 1'b0, 1'b0);

    // moc arriving on the limit cycle wins.
    run_instr(6'h02, 6'h00, 1'b0, 3, 0);

    // Reset in the middle of a fetch wait.
    nxt_op = 6'h00;
    step(S_F0, 1'b0, 1'b0);
    step(S_F1, 1'b0, 1'b0);
    step(S_F1, 1'b0, 1'b1);
    step(S_IDLE, 1'b0, 1'b0);

    run_instr(6'h00, 6'h22, 1'b0, 0, 0);
    step(S_F0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
